// File: rtl/sal_fifo_pkg.sv
// Shared types and helpers for the multi-channel FIFO.
package sal_fifo_pkg;

    function automatic int cnt_w(input int depth_lg2);
        return depth_lg2 + 1;
    endfunction

    typedef struct packed {
        logic ovf;
        logic udf;
    } sal_fifo_err_t;

endpackage

// File: rtl/sal_fifo_chctl.sv
// One channel's read/write pointers, occupancy count and registered status flags.
module sal_fifo_chctl
    import sal_fifo_pkg::*;
#(
    parameter int DEPTH_LG2    = 4,
    parameter int AFULL_THRES  = (1 << DEPTH_LG2) - 1,
    parameter int AEMPTY_THRES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wacc_i,
    input  logic                 racc_i,
    output logic [DEPTH_LG2-1:0] wrlo_o,
    output logic [DEPTH_LG2-1:0] rdlo_o,
    output logic [DEPTH_LG2:0]   cnt_o,
    output logic                 full_o,
    output logic                 afull_o,
    output logic                 empty_o,
    output logic                 aempty_o
);
    localparam int CNT_W = cnt_w(DEPTH_LG2);
    localparam logic [CNT_W-1:0] AF_TH = CNT_W'(AFULL_THRES);
    localparam logic [CNT_W-1:0] AE_TH = CNT_W'(AEMPTY_THRES);

    logic [CNT_W-1:0] r_wrptr, r_rdptr, r_cnt;
    logic             r_full, r_afull, r_empty, r_aempty;
    logic [CNT_W-1:0] w_wr_nxt, w_rd_nxt, w_cnt_nxt;

    assign w_wr_nxt = r_wrptr + CNT_W'(wacc_i);
    assign w_rd_nxt = r_rdptr + CNT_W'(racc_i);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (wacc_i && !racc_i)
            w_cnt_nxt = r_cnt + CNT_W'(1);
        else if (racc_i && !wacc_i)
            w_cnt_nxt = r_cnt - CNT_W'(1);
    end

    // Flags come from next-state pointers so they are exact the cycle after the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrptr  <= '0;
            r_rdptr  <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
        end else begin
            r_wrptr  <= w_wr_nxt;
            r_rdptr  <= w_rd_nxt;
            r_cnt    <= w_cnt_nxt;
            r_full   <= (w_wr_nxt[CNT_W-1] != w_rd_nxt[CNT_W-1]) &&
                        (w_wr_nxt[CNT_W-2:0] == w_rd_nxt[CNT_W-2:0]);
            r_empty  <= (w_wr_nxt == w_rd_nxt);
            r_afull  <= (w_cnt_nxt >= AF_TH);
            r_aempty <= (w_cnt_nxt <= AE_TH);
        end
    end

    assign wrlo_o   = r_wrptr[CNT_W-2:0];
    assign rdlo_o   = r_rdptr[CNT_W-2:0];
    assign cnt_o    = r_cnt;
    assign full_o   = r_full;
    assign afull_o  = r_afull;
    assign empty_o  = r_empty;
    assign aempty_o = r_aempty;

endmodule

// File: rtl/sal_mc_fifo.sv
// Multi-channel synchronous FIFO: NUM_CH queues in one shared array, show-ahead read, sticky errors.
module sal_mc_fifo
    import sal_fifo_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DEPTH_LG2    = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int AFULL_THRES  = (1 << DEPTH_LG2) - 1,
    parameter int AEMPTY_THRES = 1,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W       = cnt_w(DEPTH_LG2)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wren_i,
    input  logic [CH_W-1:0]         wch_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [NUM_CH-1:0]       full_o,
    output logic [NUM_CH-1:0]       afull_o,
    input  logic                    rden_i,
    input  logic [CH_W-1:0]         rch_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [NUM_CH-1:0]       empty_o,
    output logic [NUM_CH-1:0]       aempty_o,
    output logic [NUM_CH*CNT_W-1:0] cnt_o,
    input  logic                    clr_err_i,
    output logic                    ovf_o,
    output logic                    udf_o
);
    localparam int DEPTH = 1 << DEPTH_LG2;

    logic [DATA_WIDTH-1:0] r_mem [NUM_CH*DEPTH];
    sal_fifo_err_t         r_err;

    logic [NUM_CH-1:0][DEPTH_LG2-1:0] w_wrlo, w_rdlo;
    logic [NUM_CH-1:0]                w_wacc, w_racc;
    logic                             w_wch_ok, w_rch_ok;
    logic                             w_wblk, w_rblk;

    // Out-of-range channel indices (non power-of-2 NUM_CH) behave like a full/empty target.
    assign w_wch_ok = ({1'b0, wch_i} < (CH_W+1)'(NUM_CH));
    assign w_rch_ok = ({1'b0, rch_i} < (CH_W+1)'(NUM_CH));
    assign w_wblk   = !w_wch_ok || full_o[wch_i];
    assign w_rblk   = !w_rch_ok || empty_o[rch_i];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_wacc[c] = wren_i && (wch_i == CH_W'(c)) && !full_o[c];
        assign w_racc[c] = rden_i && (rch_i == CH_W'(c)) && !empty_o[c];

        sal_fifo_chctl #(
            .DEPTH_LG2   (DEPTH_LG2),
            .AFULL_THRES (AFULL_THRES),
            .AEMPTY_THRES(AEMPTY_THRES)
        ) u_chctl (
            .clk     (clk),
            .rst     (rst),
            .wacc_i  (w_wacc[c]),
            .racc_i  (w_racc[c]),
            .wrlo_o  (w_wrlo[c]),
            .rdlo_o  (w_rdlo[c]),
            .cnt_o   (cnt_o[c*CNT_W +: CNT_W]),
            .full_o  (full_o[c]),
            .afull_o (afull_o[c]),
            .empty_o (empty_o[c]),
            .aempty_o(aempty_o[c])
        );
    end

    always_ff @(posedge clk) begin
        if (|w_wacc)
            r_mem[{wch_i, w_wrlo[wch_i]}] <= wdata_i;
    end

    assign rdata_o = w_rch_ok ? r_mem[{rch_i, w_rdlo[rch_i]}] : '0;

    // A new error in the same cycle as a clear stays set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            if (clr_err_i) r_err <= '0;
            if (wren_i && w_wblk) r_err.ovf <= 1'b1;
            if (rden_i && w_rblk) r_err.udf <= 1'b1;
        end
    end

    assign ovf_o = r_err.ovf;
    assign udf_o = r_err.udf;

endmodule

// File: tb/tb_sal_mc_fifo.sv
// Directed self-checking bench for sal_mc_fifo (NUM_CH=4, depth 16, 32-bit data).
module tb_sal_mc_fifo;
    localparam int NCH = 4;
    localparam int CW  = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wren_i = 1'b0, rden_i = 1'b0, clr_err_i = 1'b0;
    logic [1:0]  wch_i = '0, rch_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic [3:0]  full_o, afull_o, empty_o, aempty_o;
    logic [19:0] cnt_o;
    logic        ovf_o, udf_o;

    int total = 0;
    int bad   = 0;

    sal_mc_fifo dut (
        .clk(clk), .rst(rst),
        .wren_i(wren_i), .wch_i(wch_i), .wdata_i(wdata_i),
        .full_o(full_o), .afull_o(afull_o),
        .rden_i(rden_i), .rch_i(rch_i), .rdata_o(rdata_o),
        .empty_o(empty_o), .aempty_o(aempty_o), .cnt_o(cnt_o),
        .clr_err_i(clr_err_i), .ovf_o(ovf_o), .udf_o(udf_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] cnt_of(input int c);
        return cnt_o[c*CW +: CW];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total++; if (empty_o !== 4'hF) begin bad++; $display("FAIL rst_empty got=%h exp=f", empty_o); end
        total++; if (aempty_o !== 4'hF) begin bad++; $display("FAIL rst_aempty got=%h exp=f", aempty_o); end
        total++; if (full_o !== 4'h0) begin bad++; $display("FAIL rst_full got=%h exp=0", full_o); end
        total++; if (afull_o !== 4'h0) begin bad++; $display("FAIL rst_afull got=%h exp=0", afull_o); end
        total++; if (cnt_o !== 20'h0) begin bad++; $display("FAIL rst_cnt got=%h exp=0", cnt_o); end
        total++; if ({ovf_o, udf_o} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b exp=00", {ovf_o, udf_o}); end
    endtask

    task automatic test_fill_ch2();
        wren_i = 1'b1; wch_i = 2'd2;
        for (int i = 0; i < 16; i++) begin
            wdata_i = 32'h100 + i;
            tick();
        end
        total++; if (full_o !== 4'b0100) begin bad++; $display("FAIL fill_full got=%b exp=0100", full_o); end
        total++; if (cnt_of(2) !== 5'd16) begin bad++; $display("FAIL fill_cnt got=%0d exp=16", cnt_of(2)); end
        total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL fill_noovf got=%b exp=0", ovf_o); end
        wdata_i = 32'hDEAD_BEEF;
        tick();
        wren_i = 1'b0;
        total++; if (ovf_o !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%b exp=1", ovf_o); end
        total++; if (cnt_of(2) !== 5'd16) begin bad++; $display("FAIL fill_cnt17 got=%0d exp=16", cnt_of(2)); end
        rch_i = 2'd2; rden_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            total++; if (rdata_o !== 32'h100 + i) begin bad++; $display("FAIL drain2[%0d] got=%h exp=%h", i, rdata_o, 32'h100 + i); end
            tick();
        end
        rden_i = 1'b0;
        total++; if (empty_o !== 4'hF) begin bad++; $display("FAIL drain2_empty got=%b exp=1111", empty_o); end
        total++; if (udf_o !== 1'b0) begin bad++; $display("FAIL drain2_noudf got=%b exp=0", udf_o); end
        clr_err_i = 1'b1; tick(); clr_err_i = 1'b0;
        total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", ovf_o); end
    endtask

    task automatic test_interleave();
        logic [31:0] seq [4];
        logic [1:0]  chs [4];
        seq = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
        chs = '{2'd0, 2'd3, 2'd0, 2'd3};
        wren_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wch_i = chs[i]; wdata_i = seq[i];
            tick();
        end
        wren_i = 1'b0;
        total++; if (empty_o !== 4'b0110) begin bad++; $display("FAIL il_empty got=%b exp=0110", empty_o); end
        rden_i = 1'b1; rch_i = 2'd0;
        #1; total++; if (rdata_o !== 32'hA0) begin bad++; $display("FAIL il_a0 got=%h exp=a0", rdata_o); end
        tick(); total++; if (rdata_o !== 32'hA1) begin bad++; $display("FAIL il_a1 got=%h exp=a1", rdata_o); end
        tick(); rch_i = 2'd3;
        #1; total++; if (rdata_o !== 32'hB0) begin bad++; $display("FAIL il_b0 got=%h exp=b0", rdata_o); end
        tick(); total++; if (rdata_o !== 32'hB1) begin bad++; $display("FAIL il_b1 got=%h exp=b1", rdata_o); end
        tick(); rden_i = 1'b0;
        total++; if (empty_o !== 4'hF) begin bad++; $display("FAIL il_drained got=%b exp=1111", empty_o); end
    endtask

    task automatic test_back_to_back();
        wren_i = 1'b1; wch_i = 2'd1; rch_i = 2'd1;
        for (int k = 0; k < 5; k++) begin
            wdata_i = 32'h1000 + k;
            tick();
        end
        total++; if (cnt_of(1) !== 5'd5) begin bad++; $display("FAIL b2b_pre got=%0d exp=5", cnt_of(1)); end
        rden_i = 1'b1;
        for (int j = 0; j < 20; j++) begin
            wdata_i = 32'h1000 + 5 + j;
            #1;
            total++; if (rdata_o !== 32'h1000 + j) begin bad++; $display("FAIL b2b_head[%0d] got=%h exp=%h", j, rdata_o, 32'h1000 + j); end
            tick();
            total++; if (cnt_of(1) !== 5'd5) begin bad++; $display("FAIL b2b_cnt[%0d] got=%0d exp=5", j, cnt_of(1)); end
        end
        wren_i = 1'b0;
        for (int j = 20; j < 25; j++) begin
            #1;
            total++; if (rdata_o !== 32'h1000 + j) begin bad++; $display("FAIL b2b_tail[%0d] got=%h exp=%h", j, rdata_o, 32'h1000 + j); end
            tick();
        end
        rden_i = 1'b0;
        total++; if ({empty_o[1], udf_o, ovf_o} !== 3'b100) begin bad++; $display("FAIL b2b_end got=%b exp=100", {empty_o[1], udf_o, ovf_o}); end
    endtask

    task automatic test_empty_simul();
        wren_i = 1'b1; rden_i = 1'b1; wch_i = 2'd1; rch_i = 2'd1; wdata_i = 32'h5A5A;
        tick();
        wren_i = 1'b0; rden_i = 1'b0;
        total++; if (cnt_of(1) !== 5'd1) begin bad++; $display("FAIL es_cnt got=%0d exp=1", cnt_of(1)); end
        total++; if (udf_o !== 1'b1) begin bad++; $display("FAIL es_udf got=%b exp=1", udf_o); end
        total++; if (rdata_o !== 32'h5A5A) begin bad++; $display("FAIL es_data got=%h exp=5a5a", rdata_o); end
        clr_err_i = 1'b1; tick(); clr_err_i = 1'b0;
        total++; if (udf_o !== 1'b0) begin bad++; $display("FAIL es_clr got=%b exp=0", udf_o); end
        clr_err_i = 1'b1; rden_i = 1'b1; rch_i = 2'd2;
        tick();
        clr_err_i = 1'b0; rden_i = 1'b0;
        total++; if (udf_o !== 1'b1) begin bad++; $display("FAIL es_setwins got=%b exp=1", udf_o); end
        clr_err_i = 1'b1; rden_i = 1'b1; rch_i = 2'd1;
        tick();
        clr_err_i = 1'b0; rden_i = 1'b0;
        total++; if ({udf_o, empty_o[1]} !== 2'b01) begin bad++; $display("FAIL es_pop got=%b exp=01", {udf_o, empty_o[1]}); end
    endtask

    task automatic test_thresholds();
        logic [2:0] ae_exp;
        wch_i = 2'd0;
        ae_exp[0] = aempty_o[0];
        wren_i = 1'b1; wdata_i = 32'h0; tick();
        ae_exp[1] = aempty_o[0];
        wdata_i = 32'h1; tick();
        ae_exp[2] = aempty_o[0];
        total++; if (ae_exp !== 3'b011) begin bad++; $display("FAIL th_aempty got=%b exp=011 (cnt2,1,0)", ae_exp); end
        for (int i = 2; i < 14; i++) begin
            wdata_i = i; tick();
        end
        total++; if ({cnt_of(0), afull_o[0]} !== {5'd14, 1'b0}) begin bad++; $display("FAIL th_af14 cnt=%0d af=%b exp=14/0", cnt_of(0), afull_o[0]); end
        wdata_i = 32'd14; tick();
        total++; if ({cnt_of(0), afull_o[0], full_o[0]} !== {5'd15, 1'b1, 1'b0}) begin bad++; $display("FAIL th_af15 cnt=%0d af=%b f=%b exp=15/1/0", cnt_of(0), afull_o[0], full_o[0]); end
        wdata_i = 32'd15; tick();
        total++; if (full_o[0] !== 1'b1) begin bad++; $display("FAIL th_full got=%b exp=1", full_o[0]); end
        wdata_i = 32'hFFFF; rden_i = 1'b1; rch_i = 2'd0;
        tick();
        wren_i = 1'b0; rden_i = 1'b0;
        total++; if ({cnt_of(0), ovf_o, full_o[0]} !== {5'd15, 1'b1, 1'b0}) begin bad++; $display("FAIL th_fullsim cnt=%0d ovf=%b f=%b exp=15/1/0", cnt_of(0), ovf_o, full_o[0]); end
        #1;
        total++; if (rdata_o !== 32'h1) begin bad++; $display("FAIL th_head got=%h exp=1", rdata_o); end
    endtask

    task automatic test_midreset();
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if ({empty_o, full_o, afull_o, ovf_o} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin bad++; $display("FAIL mrst got=%b exp=1111_0000_0000_0", {empty_o, full_o, afull_o, ovf_o}); end
        total++; if (cnt_o !== 20'h0) begin bad++; $display("FAIL mrst_cnt got=%h exp=0", cnt_o); end
    endtask

    initial begin
        test_reset();
        test_fill_ch2();
        test_interleave();
        test_back_to_back();
        test_empty_simul();
        test_thresholds();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
